// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//
// Cascadable multi-decade BCD up/down counter. Lower decades span 0..9 and the
// most-significant decade spans 0..TOP_MAX, so DIGITS=2, TOP_MAX=5 counts 00..59.
// Per-edge priority is clr, then load, then en, then hold.
//
// Parameters:
//   DIGITS   number of BCD decades (1..8)
//   TOP_MAX  largest value of the most-significant decade (1..9)
//
// Ports:
//   Clk       rising-edge clock
//   rst       asynchronous reset, active low
//   en        count enable, also the cascade carry-in
//   up        1 = increment, 0 = decrement
//   clr       synchronous clear to zero
//   load      synchronous parallel load of load_val
//   load_val  load value, decade k in bits [4k+3:4k]
//   CNT10     count value, decade k in bits [4k+3:4k]
//   tc        combinational terminal count (drives the next stage's en)
//   wrap      registered one-cycle pulse after a wrap-around edge
//   load_err  registered one-cycle pulse after a load that replaced a bad decade

module bcd_updown_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned TOP_MAX = 9
) (
    input  logic                Clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] CNT10,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    // Largest legal value of decade k.
    function automatic logic [3:0] digit_max(input int unsigned k);
        if (k == DIGITS - 1) begin
            return 4'(TOP_MAX);
        end
        return 4'd9;
    endfunction

    logic [3:0] digit_q   [DIGITS];
    logic [3:0] digit_d   [DIGITS];
    logic [3:0] step_val  [DIGITS];
    logic [3:0] load_digit[DIGITS];
    logic       load_bad;
    logic       at_max;
    logic       at_zero;
    logic       carry;
    logic       wrap_q;
    logic       wrap_d;
    logic       load_err_q;
    logic       load_err_d;

    // Terminal-value detection over all decades.
    always_comb begin
        at_max  = 1'b1;
        at_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            at_max  = at_max & (digit_q[k] == digit_max(k));
            at_zero = at_zero & (digit_q[k] == 4'd0);
        end
    end

    // No register in this path so a cascaded stage sees it in the same cycle.
    assign tc = en & ~clr & ~load & (up ? at_max : at_zero);

    // Ripple carry/borrow across decades. carry starts set so decade 0 always
    // steps; each decade passes it on only when it rolls over.
    always_comb begin
        carry = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            step_val[k] = digit_q[k];
            if (carry) begin
                if (up) begin
                    if (digit_q[k] == digit_max(k)) begin
                        step_val[k] = 4'd0;
                    end else begin
                        step_val[k] = digit_q[k] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (digit_q[k] == 4'd0) begin
                        step_val[k] = digit_max(k);
                    end else begin
                        step_val[k] = digit_q[k] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
    end

    // Out-of-range decades load as zero; the rest load unchanged.
    always_comb begin
        load_bad = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            load_digit[k] = load_val[4*k +: 4];
            if (load_val[4*k +: 4] > digit_max(k)) begin
                load_digit[k] = 4'd0;
                load_bad      = 1'b1;
            end
        end
    end

    // Next state: clr > load > en > hold.
    always_comb begin
        load_err_d = 1'b0;
        wrap_d     = tc;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            digit_d[k] = digit_q[k];
        end
        if (clr) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                digit_d[k] = 4'd0;
            end
        end else if (load) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                digit_d[k] = load_digit[k];
            end
            load_err_d = load_bad;
        end else if (en) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                digit_d[k] = step_val[k];
            end
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                digit_q[k] <= 4'd0;
            end
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                digit_q[k] <= digit_d[k];
            end
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        CNT10 = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            CNT10[4*k +: 4] = digit_q[k];
        end
    end

    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 00..59 instance checked every cycle against an
// integer model, plus a two-stage 00..99 cascade, plus literal spot checks.

module tb_bcd_updown_counter;

    localparam int DIGITS  = 2;
    localparam int TOP_MAX = 5;
    localparam int MAXV    = (TOP_MAX + 1) * (10 ** (DIGITS - 1)) - 1;  // 59

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, clr, load;
    logic [7:0] load_val;
    wire  [7:0] cnt;
    wire        tc, wrap, load_err;

    logic       c_en, c_up, c_clr;
    wire  [3:0] lo_cnt, hi_cnt;
    wire        lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(DIGITS), .TOP_MAX(TOP_MAX)) dut (
        .Clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .CNT10(cnt), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(1), .TOP_MAX(9)) u_lo (
        .Clk(clk), .rst(rst), .en(c_en), .up(c_up), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .CNT10(lo_cnt), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err)
    );

    bcd_updown_counter #(.DIGITS(1), .TOP_MAX(9)) u_hi (
        .Clk(clk), .rst(rst), .en(lo_tc), .up(c_up), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .CNT10(hi_cnt), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: plain integers ----------------
    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int load_value(input logic [7:0] lv);
        int lo = int'(lv[3:0]);
        int hi = int'(lv[7:4]);
        if (lo > 9) lo = 0;
        if (hi > TOP_MAX) hi = 0;
        return hi * 10 + lo;
    endfunction

    function automatic bit load_bad(input logic [7:0] lv);
        return (int'(lv[3:0]) > 9) || (int'(lv[7:4]) > TOP_MAX);
    endfunction

    int m_val;
    bit m_wrap, m_err;
    int c_val;

    function automatic bit m_tc();
        return en && !clr && !load && (up ? (m_val == MAXV) : (m_val == 0));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_val  <= 0;
            m_wrap <= 1'b0;
            m_err  <= 1'b0;
            c_val  <= 0;
        end else begin
            m_wrap <= m_tc();
            m_err  <= 1'b0;
            if (clr) m_val <= 0;
            else if (load) begin
                m_val <= load_value(load_val);
                m_err <= load_bad(load_val);
            end else if (en) m_val <= up ? (m_val + 1) % (MAXV + 1) : (m_val + MAXV) % (MAXV + 1);
            if (c_clr) c_val <= 0;
            else if (c_en) c_val <= c_up ? (c_val + 1) % 100 : (c_val + 99) % 100;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("cnt", 32'(cnt), 32'(to_bcd(m_val)));
        check("tc", 32'(tc), 32'(m_tc()));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("load_err", 32'(load_err), 32'(m_err));
        check("cascade", 32'({hi_cnt, lo_cnt}), 32'(to_bcd(c_val)));
    end

    // Apply inputs shortly after an edge, then advance one clock.
    task automatic step(input logic e, input logic u, input logic c, input logic l,
                        input logic [7:0] lv);
        en = e; up = u; clr = c; load = l; load_val = lv;
        @(posedge clk);
        #2;
    endtask

    int lo_pulses, hi_pulses;

    initial begin
        rst = 1'b0; en = 0; up = 1; clr = 0; load = 0; load_val = 8'h00;
        c_en = 0; c_up = 1; c_clr = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset cnt", 32'(cnt), 32'h00);
        check("reset wrap", 32'(wrap), 32'h0);
        rst = 1'b1;

        // 1: free-run up
        for (int i = 0; i < 59; i++) step(1, 1, 0, 0, 8'h00);
        check("t1 at 59", 32'(cnt), 32'h59);
        check("t1 tc at 59", 32'(tc), 32'h1);
        step(1, 1, 0, 0, 8'h00);
        check("t1 wrapped", 32'(cnt), 32'h00);
        check("t1 wrap pulse", 32'(wrap), 32'h1);
        step(1, 1, 0, 0, 8'h00);
        check("t1 wrap gone", 32'(wrap), 32'h0);
        check("t1 next", 32'(cnt), 32'h01);

        // 2: down wrap
        step(0, 1, 0, 1, 8'h01);
        step(1, 0, 0, 0, 8'h00);
        check("t2 at 00", 32'(cnt), 32'h00);
        check("t2 tc down", 32'(tc), 32'h1);
        step(1, 0, 0, 0, 8'h00);
        check("t2 to 59", 32'(cnt), 32'h59);
        check("t2 wrap", 32'(wrap), 32'h1);
        step(0, 0, 0, 0, 8'h00);
        check("t2 hold", 32'(cnt), 32'h59);
        check("t2 tc off", 32'(tc), 32'h0);
        check("t2 wrap once", 32'(wrap), 32'h0);

        // 3: priority
        step(0, 1, 0, 1, 8'h37);
        check("t3 at 37", 32'(cnt), 32'h37);
        step(1, 1, 1, 1, 8'h12);
        check("t3 clr wins", 32'(cnt), 32'h00);
        check("t3 no err", 32'(load_err), 32'h0);
        step(1, 1, 0, 1, 8'h12);
        check("t3 load over en", 32'(cnt), 32'h12);

        // 4: invalid loads
        step(0, 1, 0, 1, 8'h7A);
        check("t4 7A", 32'(cnt), 32'h00);
        check("t4 7A err", 32'(load_err), 32'h1);
        step(0, 1, 0, 1, 8'h4B);
        check("t4 4B", 32'(cnt), 32'h40);
        check("t4 4B err", 32'(load_err), 32'h1);
        step(0, 1, 0, 1, 8'h23);
        check("t4 23", 32'(cnt), 32'h23);
        check("t4 23 ok", 32'(load_err), 32'h0);
        step(0, 1, 0, 1, 8'h59);
        check("t4 59 top ok", 32'(cnt), 32'h59);
        check("t4 59 no err", 32'(load_err), 32'h0);

        // 5: async reset mid-count
        step(0, 1, 0, 1, 8'h57);
        step(1, 1, 0, 0, 8'h00);
        check("t5 at 58", 32'(cnt), 32'h58);
        #1 rst = 1'b0;
        #1;
        check("t5 async cnt", 32'(cnt), 32'h00);
        check("t5 async wrap", 32'(wrap), 32'h0);
        check("t5 async err", 32'(load_err), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(1, 1, 0, 0, 8'h00);
        check("t5 resume", 32'(cnt), 32'h01);
        en = 0;

        // 6: cascade, 100 up edges
        lo_pulses = 0; hi_pulses = 0;
        c_en = 1; c_up = 1; c_clr = 1;
        @(posedge clk);
        #2 c_clr = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 99) check("t6 at 99", 32'({hi_cnt, lo_cnt}), 32'h99);
            @(posedge clk);
            #2;
            lo_pulses += int'(lo_wrap);
            hi_pulses += int'(hi_wrap);
        end
        check("t6 wrapped", 32'({hi_cnt, lo_cnt}), 32'h00);
        check("t6 lo pulses", 32'(lo_pulses), 32'd10);
        check("t6 hi pulses", 32'(hi_pulses), 32'd1);
        c_en = 0;
        @(posedge clk);
        #2;
        check("t6 cascade errs", 32'({lo_err, hi_err}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
